// File: rtl/al_usb_pkg.sv
// Shared definitions for the USB-RX to RAM path: FSM encoding and the
// relationship between RAM beat width and 32-bit USB words per beat.
package al_usb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int USB_WORD_W = 32;

  // DATA_BITS=3 -> 2 words, DATA_BITS=4 -> 4 words per RAM beat
  function automatic int words_per_beat(input int data_bits);
    return 1 << (data_bits - 2);
  endfunction

endpackage

// File: rtl/al_usb_wpack.sv
// Packs 32-bit USB words into one RAM beat, lane 0 first. A clear zeroes
// every lane so a beat flushed early carries zeros in its unfilled lanes.
module al_usb_wpack
  import al_usb_pkg::*;
#(
  parameter int DATA_BITS = 3
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [USB_WORD_W-1:0]        word,
  output logic [(8<<DATA_BITS)-1:0]    data,
  output logic                         last_lane
);

  localparam int W  = words_per_beat(DATA_BITS);
  localparam int IW = $clog2(W);

  logic [W-1:0][USB_WORD_W-1:0] lanes;
  logic [IW-1:0]                idx;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lanes <= '0;
      idx   <= '0;
    end else if (push) begin
      lanes[idx] <= word;
      idx        <= idx + IW'(1);
    end
  end

  assign data      = lanes;
  assign last_lane = (idx == IW'(W - 1));

endmodule

// File: rtl/al_usbrx_to_ram.sv
// Writes a USB OUT word stream into local RAM, one descriptor at a time,
// and reports beats written plus whether the packet ended early.
module al_usbrx_to_ram
  import al_usb_pkg::*;
#(
  parameter int LOCAL_ADDR_WIDTH = 17,
  parameter int MEM_TAG          = 1,
  parameter int REQUEST_LEN_BITS = 6,
  parameter int DATA_BITS        = 3,
  parameter int DATA_WIDTH_      = 8 << DATA_BITS
)(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_tcq_valid,
  output logic                                 s_tcq_ready,
  input  logic [LOCAL_ADDR_WIDTH-1:DATA_BITS]  s_tcq_laddr,
  input  logic [REQUEST_LEN_BITS-1:0]          s_tcq_length,
  input  logic [MEM_TAG-1:0]                   s_tcq_tag,
  output logic                                 s_tcq_cvalid,
  input  logic                                 s_tcq_cready,
  output logic [MEM_TAG-1:0]                   s_tcq_ctag,
  output logic                                 s_tcq_cshort,
  output logic [REQUEST_LEN_BITS:0]            s_tcq_cbeats,
  input  logic [31:0]                          s_axis_usbrx_tdata,
  input  logic                                 s_axis_usbrx_tvalid,
  output logic                                 s_axis_usbrx_tready,
  input  logic                                 s_axis_usbrx_tlast,
  input  logic [3:0]                           s_axis_usbrx_tkeep,
  output logic [LOCAL_ADDR_WIDTH-1:DATA_BITS]  m_al_waddr,
  output logic [DATA_WIDTH_-1:0]               m_al_wdata,
  output logic                                 m_al_wvalid,
  input  logic                                 m_al_wready,
  output logic                                 m_al_wlast
);

  localparam int AW = LOCAL_ADDR_WIDTH - DATA_BITS;
  localparam int LW = REQUEST_LEN_BITS;

  logic [1:0]       state;
  logic [LW-1:0]    cnt;
  logic [LW:0]      tally;
  logic [MEM_TAG-1:0] tag;
  logic             short_q;
  logic             accept, push, beat_done, lane_full, pack_clr;
  logic             unused_tkeep;

  // Only one descriptor in flight, and the previous completion must be
  // taken (or be taken this cycle) before a new one is accepted.
  assign accept = (state == ST_IDLE) && s_tcq_valid && !s_tcq_ready &&
                  (!s_tcq_cvalid || s_tcq_cready);
  assign s_axis_usbrx_tready = (state == ST_COLLECT);
  assign push      = s_axis_usbrx_tready && s_axis_usbrx_tvalid;
  assign beat_done = (state == ST_WRITE) && m_al_wvalid && m_al_wready;
  assign pack_clr  = accept || beat_done;

  assign s_tcq_ctag   = tag;
  assign s_tcq_cshort = short_q;
  assign s_tcq_cbeats = tally;
  assign unused_tkeep = ^s_axis_usbrx_tkeep;

  al_usb_wpack #(.DATA_BITS(DATA_BITS)) u_wpack (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .push      (push),
    .word      (s_axis_usbrx_tdata),
    .data      (m_al_wdata),
    .last_lane (lane_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      s_tcq_ready  <= 1'b0;
      s_tcq_cvalid <= 1'b0;
      m_al_wvalid  <= 1'b0;
      m_al_wlast   <= 1'b0;
      m_al_waddr   <= '0;
      cnt          <= '0;
      tally        <= '0;
      tag          <= '0;
      short_q      <= 1'b0;
    end else begin
      s_tcq_ready <= accept;
      if (s_tcq_cvalid && s_tcq_cready) s_tcq_cvalid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          m_al_waddr <= s_tcq_laddr;
          cnt        <= s_tcq_length;
          tag        <= s_tcq_tag;
          tally      <= '0;
          short_q    <= 1'b0;
          state      <= ST_COLLECT;
        end
        ST_COLLECT: if (push && (lane_full || s_axis_usbrx_tlast)) begin
          // tlast ending exactly on the descriptor's last beat is not short
          m_al_wvalid <= 1'b1;
          m_al_wlast  <= (cnt == '0) || s_axis_usbrx_tlast;
          short_q     <= s_axis_usbrx_tlast && (cnt != '0);
          state       <= ST_WRITE;
        end
        ST_WRITE: if (beat_done) begin
          m_al_wvalid <= 1'b0;
          m_al_wlast  <= 1'b0;
          m_al_waddr  <= m_al_waddr + AW'(1);
          tally       <= tally + (LW+1)'(1);
          cnt         <= cnt - LW'(1);
          state       <= m_al_wlast ? ST_DONE : ST_COLLECT;
        end
        ST_DONE: begin
          s_tcq_cvalid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_al_usbrx_to_ram.sv
// Directed bench for al_usbrx_to_ram: one 64-bit and one 128-bit instance,
// beats and completions collected and compared against hand-built tables.
module tb_al_usbrx_to_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [15:0] addr; logic [127:0] data; logic last; } beat_t;
  typedef struct packed { logic tag; logic shrt; logic [6:0] beats; } cpl_t;
  typedef struct packed { logic [15:0] laddr; logic [5:0] len; logic tag; } desc_t;

  beat_t exp_b3[$], exp_b4[$], b3_q[$], b4_q[$];
  cpl_t  exp_c3[$], exp_c4[$], c3_q[$], c4_q[$];
  desc_t desc3_q[$], desc4_q[$];
  logic [32:0] words3_q[$], words4_q[$];

  // 64-bit instance signals
  logic        rst3 = 1'b1, wready3 = 1'b0, cready3 = 1'b0;
  logic        tcq_valid3 = 1'b0, tag3 = 1'b0, tvalid3 = 1'b0, tlast3 = 1'b0;
  logic [13:0] laddr3 = '0;
  logic [5:0]  len3 = '0;
  logic [31:0] tdata3 = '0;
  logic [3:0]  tkeep3 = 4'hf;
  logic        tcq_ready3, cvalid3, ctag3, cshort3, tready3, wvalid3, wlast3;
  logic [6:0]  cbeats3;
  logic [13:0] waddr3;
  logic [63:0] wdata3;

  // 128-bit instance signals
  logic        rst4 = 1'b1, wready4 = 1'b0, cready4 = 1'b0;
  logic        tcq_valid4 = 1'b0, tag4 = 1'b0, tvalid4 = 1'b0, tlast4 = 1'b0;
  logic [12:0] laddr4 = '0;
  logic [5:0]  len4 = '0;
  logic [31:0] tdata4 = '0;
  logic [3:0]  tkeep4 = 4'hf;
  logic        tcq_ready4, cvalid4, ctag4, cshort4, tready4, wvalid4, wlast4;
  logic [6:0]  cbeats4;
  logic [12:0] waddr4;
  logic [127:0] wdata4;

  al_usbrx_to_ram #(.DATA_BITS(3)) u_dut3 (
    .clk(clk), .rst(rst3),
    .s_tcq_valid(tcq_valid3), .s_tcq_ready(tcq_ready3), .s_tcq_laddr(laddr3),
    .s_tcq_length(len3), .s_tcq_tag(tag3),
    .s_tcq_cvalid(cvalid3), .s_tcq_cready(cready3), .s_tcq_ctag(ctag3),
    .s_tcq_cshort(cshort3), .s_tcq_cbeats(cbeats3),
    .s_axis_usbrx_tdata(tdata3), .s_axis_usbrx_tvalid(tvalid3), .s_axis_usbrx_tready(tready3),
    .s_axis_usbrx_tlast(tlast3), .s_axis_usbrx_tkeep(tkeep3),
    .m_al_waddr(waddr3), .m_al_wdata(wdata3), .m_al_wvalid(wvalid3),
    .m_al_wready(wready3), .m_al_wlast(wlast3)
  );

  al_usbrx_to_ram #(.DATA_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .s_tcq_valid(tcq_valid4), .s_tcq_ready(tcq_ready4), .s_tcq_laddr(laddr4),
    .s_tcq_length(len4), .s_tcq_tag(tag4),
    .s_tcq_cvalid(cvalid4), .s_tcq_cready(cready4), .s_tcq_ctag(ctag4),
    .s_tcq_cshort(cshort4), .s_tcq_cbeats(cbeats4),
    .s_axis_usbrx_tdata(tdata4), .s_axis_usbrx_tvalid(tvalid4), .s_axis_usbrx_tready(tready4),
    .s_axis_usbrx_tlast(tlast4), .s_axis_usbrx_tkeep(tkeep4),
    .m_al_waddr(waddr4), .m_al_wdata(wdata4), .m_al_wvalid(wvalid4),
    .m_al_wready(wready4), .m_al_wlast(wlast4)
  );

  // Handshakes are sampled mid-cycle; queues advance just after the edge.
  always begin : agent3
    logic df, wf;
    @(negedge clk);
    df = tcq_valid3 && tcq_ready3;
    wf = tvalid3 && tready3;
    if (wvalid3 && wready3) b3_q.push_back({{2'd0, waddr3}, {64'd0, wdata3}, wlast3});
    if (cvalid3 && cready3) c3_q.push_back({ctag3, cshort3, cbeats3});
    @(posedge clk); #1;
    if (df) void'(desc3_q.pop_front());
    if (wf) void'(words3_q.pop_front());
    tcq_valid3 = (desc3_q.size() != 0);
    if (tcq_valid3) begin
      laddr3 = desc3_q[0].laddr[13:0]; len3 = desc3_q[0].len; tag3 = desc3_q[0].tag;
    end
    tvalid3 = (words3_q.size() != 0);
    if (tvalid3) {tlast3, tdata3} = words3_q[0];
    else begin tlast3 = 1'b0; tdata3 = '0; end
  end

  always begin : agent4
    logic df, wf;
    @(negedge clk);
    df = tcq_valid4 && tcq_ready4;
    wf = tvalid4 && tready4;
    if (wvalid4 && wready4) b4_q.push_back({{3'd0, waddr4}, wdata4, wlast4});
    if (cvalid4 && cready4) c4_q.push_back({ctag4, cshort4, cbeats4});
    @(posedge clk); #1;
    if (df) void'(desc4_q.pop_front());
    if (wf) void'(words4_q.pop_front());
    tcq_valid4 = (desc4_q.size() != 0);
    if (tcq_valid4) begin
      laddr4 = desc4_q[0].laddr[12:0]; len4 = desc4_q[0].len; tag4 = desc4_q[0].tag;
    end
    tvalid4 = (words4_q.size() != 0);
    if (tvalid4) {tlast4, tdata4} = words4_q[0];
    else begin tlast4 = 1'b0; tdata4 = '0; end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t bt(input logic [15:0] a, input logic [127:0] d, input logic l);
    return {a, d, l};
  endfunction

  function automatic cpl_t cp(input logic t, input logic s, input logic [6:0] b);
    return {t, s, b};
  endfunction

  task automatic words3(input logic [31:0] first, input int n, input logic last);
    for (int i = 0; i < n; i++) words3_q.push_back({last && (i == n-1), first + 32'(i)});
  endtask

  task automatic words4(input logic [31:0] first, input int n, input logic last);
    for (int i = 0; i < n; i++) words4_q.push_back({last && (i == n-1), first + 32'(i)});
  endtask

  task automatic wait_cpl3(input int n);
    int k = 0;
    while (c3_q.size() < n && k < 500) begin @(posedge clk); #1; k++; end
    check($sformatf("cpl3 arrival %0d", n), 256'(c3_q.size() >= n), 256'(1));
  endtask

  task automatic wait_cpl4(input int n);
    int k = 0;
    while (c4_q.size() < n && k < 500) begin @(posedge clk); #1; k++; end
    check($sformatf("cpl4 arrival %0d", n), 256'(c4_q.size() >= n), 256'(1));
  endtask

  initial begin
    logic [78:0] snap;
    int k;

    // 64-bit expectations: 8-word burst, packet spanning two descriptors,
    // wready stall, cready hold-off, reset mid-burst then a clean descriptor
    exp_b3.push_back(bt(16'h100, 128'h00000002_00000001, 1'b0));
    exp_b3.push_back(bt(16'h101, 128'h00000004_00000003, 1'b0));
    exp_b3.push_back(bt(16'h102, 128'h00000006_00000005, 1'b0));
    exp_b3.push_back(bt(16'h103, 128'h00000008_00000007, 1'b1));
    exp_b3.push_back(bt(16'h200, 128'h00000012_00000011, 1'b0));
    exp_b3.push_back(bt(16'h201, 128'h00000014_00000013, 1'b1));
    exp_b3.push_back(bt(16'h300, 128'h00000016_00000015, 1'b1));
    exp_b3.push_back(bt(16'h400, 128'h00000022_00000021, 1'b0));
    exp_b3.push_back(bt(16'h401, 128'h00000024_00000023, 1'b1));
    exp_b3.push_back(bt(16'h500, 128'h00000032_00000031, 1'b1));
    exp_b3.push_back(bt(16'h600, 128'h00000042_00000041, 1'b1));
    exp_b3.push_back(bt(16'h700, 128'h00000052_00000051, 1'b0));
    exp_b3.push_back(bt(16'h710, 128'h00000062_00000061, 1'b1));
    exp_c3.push_back(cp(1'b1, 1'b0, 7'd4));
    exp_c3.push_back(cp(1'b0, 1'b0, 7'd2));
    exp_c3.push_back(cp(1'b1, 1'b1, 7'd1));
    exp_c3.push_back(cp(1'b0, 1'b0, 7'd2));
    exp_c3.push_back(cp(1'b1, 1'b0, 7'd1));
    exp_c3.push_back(cp(1'b0, 1'b0, 7'd1));
    exp_c3.push_back(cp(1'b0, 1'b0, 7'd1));
    // 128-bit: short 3-word packet, then a 10-word packet over two descriptors
    exp_b4.push_back(bt(16'h020, 128'h00000000_000000a3_000000a2_000000a1, 1'b1));
    exp_b4.push_back(bt(16'h030, 128'h000000b4_000000b3_000000b2_000000b1, 1'b0));
    exp_b4.push_back(bt(16'h031, 128'h000000b8_000000b7_000000b6_000000b5, 1'b1));
    exp_b4.push_back(bt(16'h040, 128'h00000000_00000000_000000ba_000000b9, 1'b1));
    exp_c4.push_back(cp(1'b1, 1'b1, 7'd1));
    exp_c4.push_back(cp(1'b0, 1'b0, 7'd2));
    exp_c4.push_back(cp(1'b1, 1'b1, 7'd1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset3 outputs", 256'({tcq_ready3, cvalid3, tready3, wvalid3, wlast3}), 256'(0));
    check("reset4 outputs", 256'({tcq_ready4, cvalid4, tready4, wvalid4, wlast4}), 256'(0));
    @(posedge clk); #1;
    rst3 = 1'b0; rst4 = 1'b0;
    wready3 = 1'b1; cready3 = 1'b1; wready4 = 1'b1; cready4 = 1'b1;

    desc4_q.push_back({16'h020, 6'd1, 1'b1});
    words4(32'ha1, 3, 1'b1);
    desc4_q.push_back({16'h030, 6'd1, 1'b0});
    desc4_q.push_back({16'h040, 6'd1, 1'b1});
    words4(32'hb1, 10, 1'b1);

    desc3_q.push_back({16'h100, 6'd3, 1'b1});
    words3(32'h1, 8, 1'b1);
    wait_cpl3(1);

    desc3_q.push_back({16'h200, 6'd1, 1'b0});
    desc3_q.push_back({16'h300, 6'd1, 1'b1});
    words3(32'h11, 6, 1'b1);
    wait_cpl3(3);

    // write channel stall: beat must hold and the stream must be held off
    wready3 = 1'b0;
    desc3_q.push_back({16'h400, 6'd1, 1'b0});
    words3(32'h21, 4, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!wvalid3 && k < 100);
    check("stall wvalid seen", 256'(wvalid3), 256'(1));
    snap = {waddr3, wdata3, wlast3};
    repeat (5) begin
      @(negedge clk);
      check("stall hold", 256'({waddr3, wdata3, wlast3, wvalid3, tready3}), 256'({snap, 2'b10}));
    end
    @(posedge clk); #1;
    wready3 = 1'b1;
    wait_cpl3(4);

    // completion not taken: the queued descriptor must wait
    cready3 = 1'b0;
    desc3_q.push_back({16'h500, 6'd0, 1'b1});
    desc3_q.push_back({16'h600, 6'd0, 1'b0});
    words3(32'h31, 2, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!cvalid3 && k < 100);
    check("cvalid seen", 256'(cvalid3), 256'(1));
    repeat (5) begin
      @(negedge clk);
      check("cready hold-off", 256'({cvalid3, tcq_ready3, tready3, desc3_q.size() == 1}), 256'(4'b1001));
    end
    @(posedge clk); #1;
    cready3 = 1'b1;
    words3(32'h41, 2, 1'b1);
    wait_cpl3(6);

    // reset after three words of a four-beat descriptor
    desc3_q.push_back({16'h700, 6'd3, 1'b1});
    words3(32'h51, 3, 1'b0);
    k = 0;
    do begin @(posedge clk); #2; k++; end while (words3_q.size() != 0 && k < 100);
    check("mid-burst words taken", 256'(words3_q.size()), 256'(0));
    rst3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst mid-burst valids", 256'({tcq_ready3, cvalid3, tready3, wvalid3, wlast3}), 256'(0));
    @(posedge clk); #1;
    rst3 = 1'b0;
    desc3_q.push_back({16'h710, 6'd0, 1'b0});
    words3(32'h61, 2, 1'b1);
    wait_cpl3(7);
    wait_cpl4(3);
    repeat (10) @(posedge clk);

    check("beats3 count", 256'(b3_q.size()), 256'(exp_b3.size()));
    foreach (exp_b3[i])
      if (i < b3_q.size()) check($sformatf("beat3[%0d]", i), 256'(b3_q[i]), 256'(exp_b3[i]));
    check("cpl3 count", 256'(c3_q.size()), 256'(exp_c3.size()));
    foreach (exp_c3[i])
      if (i < c3_q.size()) check($sformatf("cpl3[%0d]", i), 256'(c3_q[i]), 256'(exp_c3[i]));
    check("beats4 count", 256'(b4_q.size()), 256'(exp_b4.size()));
    foreach (exp_b4[i])
      if (i < b4_q.size()) check($sformatf("beat4[%0d]", i), 256'(b4_q[i]), 256'(exp_b4[i]));
    check("cpl4 count", 256'(c4_q.size()), 256'(exp_c4.size()));
    foreach (exp_c4[i])
      if (i < c4_q.size()) check($sformatf("cpl4[%0d]", i), 256'(c4_q[i]), 256'(exp_c4[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
